// File: rtl/spi_ram_responder.sv
// SPI mode-0 slave that models a 23LC512-style serial SRAM backed by an internal byte array.
// It accepts READ (0x03) and WRITE (0x02) with sequential bursts. All SPI pins are oversampled on clk.
module spi_ram_responder #(
  parameter int unsigned ADDR_BITS     = 16,
  parameter int unsigned MEM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     spi_select,
  input  logic                     spi_clk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic                     active,
  output logic                     cmd_error,
  input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
  output logic [7:0]               dbg_data
);

  localparam int unsigned DEPTH    = 1 << MEM_ADDR_BITS;
  localparam int unsigned ACW      = $clog2(ADDR_BITS);
  localparam logic [7:0]  OP_WRITE = 8'h02;
  localparam logic [7:0]  OP_READ  = 8'h03;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE_DATA, READ_DATA, IGNORE} state_t;

  state_t                 state;
  logic [1:0]             sel_sync, sck_sync, mosi_sync;
  logic                   sel_d, sck_d;
  logic [7:0]             shift_in, shift_out;
  logic [2:0]             bit_cnt;
  logic [ACW-1:0]         addr_bit_cnt;
  logic [ADDR_BITS-1:0]   addr;
  logic                   is_read, fall_armed;
  logic [7:0]             mem [DEPTH];

  logic                   mosi, sck_rise, sck_fall, cs_high, cs_fall, byte_done, mem_we;
  logic [7:0]             byte_in, rd_first, rd_next;
  logic [ADDR_BITS-1:0]   addr_shifted, addr_inc;

  assign mosi         = mosi_sync[1];
  assign cs_high      = sel_sync[1];
  assign sck_rise     = sck_sync[1] & ~sck_d;
  assign sck_fall     = ~sck_sync[1] & sck_d;
  assign cs_fall      = ~sel_sync[1] & sel_d;
  assign byte_in      = {shift_in[6:0], mosi};
  assign byte_done    = sck_rise && (bit_cnt == 3'd7);
  assign addr_shifted = {addr[ADDR_BITS-2:0], mosi};
  assign addr_inc     = addr + ADDR_BITS'(1);
  assign rd_first     = mem[addr_shifted[MEM_ADDR_BITS-1:0]];
  assign rd_next      = mem[addr_inc[MEM_ADDR_BITS-1:0]];
  assign mem_we       = (state == WRITE_DATA) && !cs_high && byte_done;
  assign dbg_data     = mem[dbg_addr];

  // Two-flop synchronizers plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_sync  <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sel_d     <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      sel_sync  <= {sel_sync[0], spi_select};
      sck_sync  <= {sck_sync[0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sel_d     <= sel_sync[1];
      sck_d     <= sck_sync[1];
    end
  end

  // Protocol FSM; CS high overrides everything and drops any partial byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      shift_in     <= 8'h00;
      shift_out    <= 8'h00;
      bit_cnt      <= 3'd0;
      addr_bit_cnt <= '0;
      addr         <= '0;
      is_read      <= 1'b0;
      fall_armed   <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      active       <= 1'b0;
      cmd_error    <= 1'b0;
    end else if (cs_high) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      fall_armed  <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      active      <= 1'b0;
    end else begin
      active <= 1'b1;
      if (sck_rise && state != IDLE) begin
        shift_in <= byte_in;
        bit_cnt  <= bit_cnt + 3'd1;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state        <= CMD;
            cmd_error    <= 1'b0;
            bit_cnt      <= 3'd0;
            addr_bit_cnt <= '0;
          end
        end
        CMD: begin
          if (byte_done) begin
            if (byte_in == OP_WRITE || byte_in == OP_READ) begin
              state   <= ADDR;
              is_read <= (byte_in == OP_READ);
            end else begin
              state     <= IGNORE;
              cmd_error <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr         <= addr_shifted;
            addr_bit_cnt <= addr_bit_cnt + ACW'(1);
            if (addr_bit_cnt == ACW'(ADDR_BITS - 1)) begin
              if (is_read) begin
                state       <= READ_DATA;
                shift_out   <= rd_first;
                spi_miso    <= rd_first[7];
                spi_miso_oe <= 1'b1;
                fall_armed  <= 1'b0;
              end else begin
                state <= WRITE_DATA;
              end
            end
          end
        end
        WRITE_DATA: begin
          if (byte_done) addr <= addr_inc;
        end
        READ_DATA: begin
          // The fall that trails the last address bit is not a data fall
          if (sck_rise) begin
            fall_armed <= 1'b1;
          end else if (sck_fall && fall_armed) begin
            fall_armed <= 1'b0;
            if (bit_cnt == 3'd0) begin
              addr      <= addr_inc;
              shift_out <= rd_next;
              spi_miso  <= rd_next[7];
            end else begin
              shift_out <= {shift_out[6:0], 1'b0};
              spi_miso  <= shift_out[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rstn
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr[MEM_ADDR_BITS-1:0]] <= byte_in;
  end

endmodule
